// File: rtl/bram_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : bram_lsu
//  Brief    : RISC-V load/store unit in front of a synchronous block RAM.
//             Four-state sequencer (IDLE/ACCESS/CAPTURE/RESP) that issues
//             exactly one memory cycle per accepted request, lane-replicates
//             store data, and sign/zero-extends load results.
//  Config   : define BRAM_LSU_MISALIGN_TRAP_EN to reject misaligned halfword
//             and word accesses with err=1 (no memory cycle is issued).
//  Revision : 1.0 - initial release
// ============================================================================
module bram_lsu #(
  parameter int RAM_ADDR_WIDTH = 13
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_i,
  input  logic                      wr_i,
  input  logic [2:0]                funct3_i,
  input  logic [31:0]               addr_i,
  input  logic [31:0]               wdata_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [31:0]               rdata_o,
  output logic                      mem_rd_o,
  output logic [3:0]                mem_we_o,
  output logic [RAM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]               mem_data_o,
  input  logic [31:0]               mem_out_i
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  state_t                    state_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      err_q;
  logic [31:0]               rdata_q;
  logic                      wr_q;
  logic [2:0]                funct3_q;
  logic [RAM_ADDR_WIDTH+1:0] addr_q;
  logic [3:0]                be_q;
  logic [31:0]               mdata_q;

  logic [3:0]                be_d;
  logic [31:0]               mdata_d;
  logic                      reject_d;
  logic [31:0]               rdata_d;
  logic [7:0]                lane_b;
  logic [15:0]               lane_h;

  // Address bits above the RAM window are intentionally dropped (wrap).
  logic                      unused_addr_hi;
  assign unused_addr_hi = ^addr_i[31:RAM_ADDR_WIDTH+2];

  // Decode the incoming request: byte enables, replicated store data, reject.
  always_comb begin
    be_d     = 4'b0000;
    mdata_d  = wdata_i;
    reject_d = 1'b0;
    case (funct3_i)
      3'b000: begin
        be_d    = 4'b0001 << addr_i[1:0];
        mdata_d = {4{wdata_i[7:0]}};
      end
      3'b001: begin
        be_d    = 4'b0011 << {addr_i[1], 1'b0};
        mdata_d = {2{wdata_i[15:0]}};
`ifdef BRAM_LSU_MISALIGN_TRAP_EN
        reject_d = addr_i[0];
`endif
      end
      3'b010: begin
        be_d    = 4'b1111;
        mdata_d = wdata_i;
`ifdef BRAM_LSU_MISALIGN_TRAP_EN
        reject_d = |addr_i[1:0];
`endif
      end
      3'b100: begin
        // LBU has no store counterpart.
        reject_d = wr_i;
      end
      3'b101: begin
        // LHU has no store counterpart.
`ifdef BRAM_LSU_MISALIGN_TRAP_EN
        reject_d = wr_i | addr_i[0];
`else
        reject_d = wr_i;
`endif
      end
      default: reject_d = 1'b1;
    endcase
  end

  // Select the addressed lane of the RAM word and extend it to 32 bits.
  always_comb begin
    lane_b = mem_out_i[7:0];
    case (addr_q[1:0])
      2'd0:    lane_b = mem_out_i[7:0];
      2'd1:    lane_b = mem_out_i[15:8];
      2'd2:    lane_b = mem_out_i[23:16];
      default: lane_b = mem_out_i[31:24];
    endcase
    lane_h = addr_q[1] ? mem_out_i[31:16] : mem_out_i[15:0];
    case (funct3_q)
      3'b000:  rdata_d = {{24{lane_b[7]}}, lane_b};
      3'b100:  rdata_d = {24'h000000, lane_b};
      3'b001:  rdata_d = {{16{lane_h[15]}}, lane_h};
      3'b101:  rdata_d = {16'h0000, lane_h};
      default: rdata_d = mem_out_i;
    endcase
  end

  // Sequencer with registered status outputs and captured request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0000_0000;
      wr_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      be_q     <= 4'b0000;
      mdata_q  <= 32'h0000_0000;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            wr_q     <= wr_i;
            funct3_q <= funct3_i;
            addr_q   <= addr_i[RAM_ADDR_WIDTH+1:0];
            be_q     <= be_d;
            mdata_q  <= mdata_d;
            busy_q   <= 1'b1;
            if (reject_d) begin
              // Rejected requests skip the memory cycle entirely.
              state_q <= ST_RESP;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (wr_q) begin
            state_q <= ST_RESP;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          rdata_q <= rdata_d;
          state_q <= ST_RESP;
          done_q  <= 1'b1;
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign rdata_o    = rdata_q;
  // Memory strobes decode from state only, so reset drops them at once.
  assign mem_rd_o   = ~((state_q == ST_ACCESS) & ~wr_q);
  assign mem_we_o   = ((state_q == ST_ACCESS) & wr_q) ? be_q : 4'b0000;
  assign mem_addr_o = addr_q[RAM_ADDR_WIDTH+1:2];
  assign mem_data_o = mdata_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bram_lsu
//  Brief    : Self-checking bench for bram_lsu with a byte-level memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bram_lsu;
  localparam int AW = 13;
`ifdef BRAM_LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          wr = 1'b0;
  logic [2:0]    funct3 = 3'b000;
  logic [31:0]   addr = 32'h0;
  logic [31:0]   wdata = 32'h0;
  logic          busy, done, err, mem_rd;
  logic [31:0]   rdata, mem_data;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_out = 32'h0;

  logic [31:0]   bram    [0:(1<<AW)-1];
  logic [7:0]    ref_mem [0:(4<<AW)-1];
  logic [31:0]   ref_rdata;
  int            n_checks = 0;
  int            n_fail = 0;

  bram_lsu #(.RAM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .wr_i(wr), .funct3_i(funct3),
    .addr_i(addr), .wdata_i(wdata), .busy_o(busy), .done_o(done), .err_o(err),
    .rdata_o(rdata), .mem_rd_o(mem_rd), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_data_o(mem_data), .mem_out_i(mem_out)
  );

  always #5 clk = ~clk;

  // Synchronous block RAM: registered read, byte-enabled write.
  always @(posedge clk) begin
    if (!mem_rd) mem_out <= bram[mem_addr];
    for (int i = 0; i < 4; i++)
      if (mem_we[i]) bram[mem_addr][8*i +: 8] <= mem_data[8*i +: 8];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_err(input logic w, input logic [2:0] f3, input logic [31:0] a);
    int size;
    bit sup;
    bit misal;
    size  = 1 << f3[1:0];
    sup   = (f3 inside {3'd0, 3'd1, 3'd2}) || (!w && (f3 inside {3'd4, 3'd5}));
    misal = (int'(a[1:0]) % size) != 0;
    return !sup || (TRAP && misal);
  endfunction

  // One complete transaction, checked against the byte-level model.
  task automatic access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold);
    int size, widx, base, off, cyc, rd_cnt, we_cnt, lat_exp;
    bit e, seen;
    logic [3:0]  be_exp;
    logic [31:0] dat_exp, val;
    size = 1 << f3[1:0];
    e    = is_err(w, f3, a);
    widx = int'(a[AW+1:2]);
    base = widx * 4 + (int'(a[1:0]) / size) * size;
    off  = base % 4;
    for (int i = 0; i < 4; i++) begin
      be_exp[i] = (i >= off) && (i < off + size);
      dat_exp[8*i +: 8] = wd[8*(i % size) +: 8];
    end
    val = 32'h0;
    if (size < 8) begin
      for (int k = size - 1; k >= 0; k--) val = (val << 8) | 32'(ref_mem[base + k]);
      if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~((32'd1 << (8*size)) - 32'd1);
    end
    lat_exp = e ? 1 : (w ? 2 : 3);

    req = 1'b1; wr = w; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk); #1;
    if (!hold) req = 1'b0;
    wr = 1'($urandom_range(0, 1)); funct3 = 3'($urandom_range(0, 7));
    addr = $urandom; wdata = $urandom;
    check("busy_c1", 32'(busy), 32'd1);
    if (!e && w) begin
      check("st_addr", 32'(mem_addr), 32'(widx));
      check("st_we", 32'(mem_we), 32'(be_exp));
      check("st_data", mem_data, dat_exp);
    end else if (!e) begin
      check("ld_addr", 32'(mem_addr), 32'(widx));
      check("ld_rd", 32'(mem_rd), 32'd0);
    end
    cyc = 1; rd_cnt = 0; we_cnt = 0; seen = 0;
    while (1) begin
      if (!mem_rd) rd_cnt++;
      if (mem_we != 4'b0000) we_cnt++;
      if (done) begin seen = 1; break; end
      if (cyc >= 8) break;
      @(posedge clk); #1;
      cyc++;
    end
    if (!e && !w) ref_rdata = val;
    if (!e && w)
      for (int k = 0; k < size; k++) ref_mem[base + k] = wd[8*k +: 8];
    check("latency", seen ? 32'(cyc) : 32'd99, 32'(lat_exp));
    check("err", 32'(err), 32'(e));
    check("busy_resp", 32'(busy), 32'd1);
    check("rdata", rdata, ref_rdata);
    check("rd_strobes", 32'(rd_cnt), (!e && !w) ? 32'd1 : 32'd0);
    check("we_strobes", 32'(we_cnt), (!e && w) ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    req = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("no_reaccept", 32'({busy, done}), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    for (int i = 0; i < (1 << AW); i++) bram[i] = 32'h0;
    for (int i = 0; i < (4 << AW); i++) ref_mem[i] = 8'h00;
    ref_rdata = 32'h0;

    // Reset state
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_err", 32'({done, err}), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_mem_rd", 32'(mem_rd), 32'd1);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_data", mem_data, 32'h0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
    access(1'b1, 3'b000, 32'h13, 32'h000000A5, 1'b0);
    access(1'b0, 3'b000, 32'h13, 32'h0, 1'b0);
    check("lb_13", rdata, 32'hFFFFFFA5);
    access(1'b0, 3'b100, 32'h13, 32'h0, 1'b1);
    check("lbu_13", rdata, 32'h000000A5);
    access(1'b1, 3'b010, 32'h10, 32'h80017FFF, 1'b0);
    access(1'b0, 3'b001, 32'h12, 32'h0, 1'b0);
    check("lh_12", rdata, 32'hFFFF8001);
    access(1'b0, 3'b101, 32'h12, 32'h0, 1'b0);
    check("lhu_12", rdata, 32'h00008001);
    access(1'b0, 3'b001, 32'h10, 32'h0, 1'b0);
    check("lh_10", rdata, 32'h00007FFF);
    access(1'b0, 3'b010, 32'h11, 32'h0, 1'b0);
    check("lw_11", rdata, TRAP ? 32'h00007FFF : 32'h80017FFF);
    access(1'b0, 3'b011, 32'h10, 32'h0, 1'b1);
    access(1'b1, 3'b101, 32'h10, 32'h0, 1'b0);

    // Randomized traffic in a small window plus upper-bit aliasing
    for (int n = 0; n < 60; n++) begin
      a = 32'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_8000);
      access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
             1'($urandom_range(0, 1)));
    end

    // Reset during a store's ACCESS cycle aborts it
    access(1'b1, 3'b010, 32'h20, 32'h11223344, 1'b0);
    req = 1'b1; wr = 1'b1; funct3 = 3'b010; addr = 32'h20; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req = 1'b0;
    check("abort_we_before", 32'(mem_we), 32'hF);
    #1 rst_n = 1'b0;
    #1;
    check("abort_we_async", 32'(mem_we), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    ref_rdata = 32'h0;
    @(posedge clk); #1;
    check("abort_no_done", 32'(done), 32'd0);
    check("abort_we_held", 32'(mem_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 3'b010, 32'h20, 32'h0, 1'b0);
    check("abort_prior", rdata, 32'h11223344);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
